// File: rtl/mc_mips_controller.sv
`default_nettype none
// ============================================================================
// mc_mips_controller : multi-cycle MIPS main control FSM (IF/ID/EX/MEM/WB)
// Rev 1.0
// ============================================================================
module mc_mips_controller (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] Opcode,
  input  logic [5:0] Funct,
  input  logic       Zero,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] RegDst,
  output logic [1:0] MemtoReg,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSrc,
  output logic [2:0] ALUCtrl,
  output logic       Illegal
);

  localparam logic [5:0] c_OP_RTYPE = 6'b000000;
  localparam logic [5:0] c_OP_LW    = 6'b100011;
  localparam logic [5:0] c_OP_SW    = 6'b101011;
  localparam logic [5:0] c_OP_BEQ   = 6'b000100;
  localparam logic [5:0] c_OP_J     = 6'b000010;
  localparam logic [5:0] c_OP_JAL   = 6'b000011;
  localparam logic [5:0] c_OP_ADDI  = 6'b001000;
  localparam logic [5:0] c_OP_SLTI  = 6'b001010;

  localparam logic [5:0] c_FN_ADD = 6'b100000;
  localparam logic [5:0] c_FN_SUB = 6'b100010;
  localparam logic [5:0] c_FN_AND = 6'b100100;
  localparam logic [5:0] c_FN_OR  = 6'b100101;
  localparam logic [5:0] c_FN_SLT = 6'b101010;
  localparam logic [5:0] c_FN_JR  = 6'b001000;

  localparam logic [2:0] c_ALU_AND = 3'b000;
  localparam logic [2:0] c_ALU_OR  = 3'b001;
  localparam logic [2:0] c_ALU_ADD = 3'b010;
  localparam logic [2:0] c_ALU_SUB = 3'b110;
  localparam logic [2:0] c_ALU_SLT = 3'b111;

  typedef enum logic [3:0] {
    S_IF, S_ID, S_EX_R, S_WB_R, S_MEM_ADDR, S_MEM_RD, S_WB_LW,
    S_MEM_WR, S_BEQ, S_J, S_JAL, S_JR, S_EX_I, S_WB_I
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] alu_op_q, alu_op_d;
  logic       illegal_id;

  // Branch qualification with Zero happens in the datapath.
  logic unused_zero;
  assign unused_zero = Zero;

  always_comb begin
    state_d    = state_q;
    alu_op_d   = alu_op_q;
    illegal_id = 1'b0;
    case (state_q)
      S_IF: state_d = S_ID;
      S_ID: begin
        case (Opcode)
          c_OP_RTYPE: begin
            state_d = S_EX_R;
            case (Funct)
              c_FN_ADD: alu_op_d = c_ALU_ADD;
              c_FN_SUB: alu_op_d = c_ALU_SUB;
              c_FN_AND: alu_op_d = c_ALU_AND;
              c_FN_OR:  alu_op_d = c_ALU_OR;
              c_FN_SLT: alu_op_d = c_ALU_SLT;
              c_FN_JR:  state_d  = S_JR;
              default: begin
                state_d    = S_IF;
                illegal_id = 1'b1;
              end
            endcase
          end
          c_OP_LW, c_OP_SW: state_d = S_MEM_ADDR;
          c_OP_BEQ:  state_d = S_BEQ;
          c_OP_J:    state_d = S_J;
          c_OP_JAL:  state_d = S_JAL;
          c_OP_ADDI: begin
            state_d  = S_EX_I;
            alu_op_d = c_ALU_ADD;
          end
          c_OP_SLTI: begin
            state_d  = S_EX_I;
            alu_op_d = c_ALU_SLT;
          end
          default: begin
            state_d    = S_IF;
            illegal_id = 1'b1;
          end
        endcase
      end
      S_EX_R:     state_d = S_WB_R;
      S_MEM_ADDR: state_d = (Opcode == c_OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   state_d = S_WB_LW;
      S_EX_I:     state_d = S_WB_I;
      default:    state_d = S_IF;
    endcase
    if (rst) begin
      state_d  = S_IF;
      alu_op_d = c_ALU_AND;
    end
  end

  always_ff @(posedge clk) begin
    state_q  <= state_d;
    alu_op_q <= alu_op_d;
  end

  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 2'b00;
    MemtoReg    = 2'b00;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    PCSrc       = 2'b00;
    ALUCtrl     = 3'b000;
    Illegal     = 1'b0;
    case (state_q)
      S_IF: begin
        MemRead = 1'b1;
        IRWrite = 1'b1;
        ALUSrcB = 2'b01;
        ALUCtrl = c_ALU_ADD;
        PCWrite = 1'b1;
      end
      S_ID: begin
        ALUSrcB = 2'b11;
        ALUCtrl = c_ALU_ADD;
        Illegal = illegal_id;
      end
      S_EX_R: begin
        ALUSrcA = 1'b1;
        ALUCtrl = alu_op_q;
      end
      S_WB_R: begin
        RegDst   = 2'b01;
        RegWrite = 1'b1;
      end
      S_MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ALUCtrl = c_ALU_ADD;
      end
      S_MEM_RD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_WB_LW: begin
        MemtoReg = 2'b01;
        RegWrite = 1'b1;
      end
      S_MEM_WR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_BEQ: begin
        ALUSrcA     = 1'b1;
        ALUCtrl     = c_ALU_SUB;
        PCWriteCond = 1'b1;
        PCSrc       = 2'b01;
      end
      S_J: begin
        PCWrite = 1'b1;
        PCSrc   = 2'b10;
      end
      S_JAL: begin
        PCWrite  = 1'b1;
        PCSrc    = 2'b10;
        RegWrite = 1'b1;
        RegDst   = 2'b10;
        MemtoReg = 2'b10;
      end
      S_JR: begin
        PCWrite = 1'b1;
        PCSrc   = 2'b11;
      end
      S_EX_I: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ALUCtrl = alu_op_q;
      end
      S_WB_I: RegWrite = 1'b1;
      default: ;
    endcase
    // Reset suppresses every strobe in the same cycle, so no partial write.
    if (rst) begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      RegWrite    = 1'b0;
      RegDst      = 2'b00;
      MemtoReg    = 2'b00;
      ALUSrcA     = 1'b0;
      ALUSrcB     = 2'b00;
      PCSrc       = 2'b00;
      ALUCtrl     = 3'b000;
      Illegal     = 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mc_mips_controller.sv
`default_nettype none
// ============================================================================
// tb_mc_mips_controller : directed cycle-by-cycle check of the control FSM
// Rev 1.0
// ============================================================================
module tb_mc_mips_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] Opcode, Funct;
  logic       Zero;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite;
  logic [1:0] RegDst, MemtoReg, ALUSrcB, PCSrc;
  logic       ALUSrcA, Illegal;
  logic [2:0] ALUCtrl;

  int tests = 0;
  int fails = 0;

  mc_mips_controller dut (
    .clk(clk), .rst(rst), .Opcode(Opcode), .Funct(Funct), .Zero(Zero),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegWrite(RegWrite), .RegDst(RegDst), .MemtoReg(MemtoReg),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSrc(PCSrc),
    .ALUCtrl(ALUCtrl), .Illegal(Illegal)
  );

  always #5 clk = ~clk;

  logic [19:0] obs;
  assign obs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite,
                RegDst, MemtoReg, ALUSrcA, ALUSrcB, PCSrc, ALUCtrl, Illegal};

  function automatic logic [19:0] v(
    input logic pcw, pcwc, iord, mr, mw, irw, rw,
    input logic [1:0] rd, mtr, input logic asa, input logic [1:0] asb, pcs,
    input logic [2:0] alu, input logic ill);
    return {pcw, pcwc, iord, mr, mw, irw, rw, rd, mtr, asa, asb, pcs, alu, ill};
  endfunction

  logic [19:0] V_ZERO, V_IF, V_ID, V_ID_ILL, V_EXR_ADD, V_EXR_SUB, V_EXR_SLT,
               V_WBR, V_MADDR, V_MRD, V_WBLW, V_MWR, V_BEQ, V_J, V_JAL, V_JR,
               V_EXI_ADD, V_EXI_SLT, V_WBI;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [19:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic instr(input logic [5:0] op, input logic [5:0] fn);
    Opcode = op;
    Funct  = fn;
  endtask

  initial begin
    //           pcw pcwc iord mr mw irw rw rd    mtr   asa asb   pcs   alu     ill
    V_ZERO    = v(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 3'b000, 0);
    V_IF      = v(1, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 0, 2'b01, 2'b00, 3'b010, 0);
    V_ID      = v(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 2'b11, 2'b00, 3'b010, 0);
    V_ID_ILL  = v(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 2'b11, 2'b00, 3'b010, 1);
    V_EXR_ADD = v(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 2'b00, 2'b00, 3'b010, 0);
    V_EXR_SUB = v(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 2'b00, 2'b00, 3'b110, 0);
    V_EXR_SLT = v(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 2'b00, 2'b00, 3'b111, 0);
    V_WBR     = v(0, 0, 0, 0, 0, 0, 1, 2'b01, 2'b00, 0, 2'b00, 2'b00, 3'b000, 0);
    V_MADDR   = v(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 2'b10, 2'b00, 3'b010, 0);
    V_MRD     = v(0, 0, 1, 1, 0, 0, 0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 3'b000, 0);
    V_WBLW    = v(0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 0, 2'b00, 2'b00, 3'b000, 0);
    V_MWR     = v(0, 0, 1, 0, 1, 0, 0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 3'b000, 0);
    V_BEQ     = v(0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 2'b00, 2'b01, 3'b110, 0);
    V_J       = v(1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 2'b00, 2'b10, 3'b000, 0);
    V_JAL     = v(1, 0, 0, 0, 0, 0, 1, 2'b10, 2'b10, 0, 2'b00, 2'b10, 3'b000, 0);
    V_JR      = v(1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 2'b00, 2'b11, 3'b000, 0);
    V_EXI_ADD = v(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 2'b10, 2'b00, 3'b010, 0);
    V_EXI_SLT = v(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 2'b10, 2'b00, 3'b111, 0);
    V_WBI     = v(0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 0, 2'b00, 2'b00, 3'b000, 0);

    rst = 1'b1; Zero = 1'b0;
    instr(6'b000000, 6'b100000);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("reset hold", V_ZERO);
    end
    rst = 1'b0;
    #1;
    chk("first fetch", V_IF);

    // add: 4 cycles
    step(); chk("add ID", V_ID);
    step(); chk("add EX_R", V_EXR_ADD);
    step(); chk("add WB_R", V_WBR);
    step(); chk("add->IF", V_IF);

    // sub
    instr(6'b000000, 6'b100010);
    step(); chk("sub ID", V_ID);
    step(); chk("sub EX_R", V_EXR_SUB);
    step(); chk("sub WB_R", V_WBR);
    step(); chk("sub->IF", V_IF);

    // slt
    instr(6'b000000, 6'b101010);
    step(); chk("slt ID", V_ID);
    step(); chk("slt EX_R", V_EXR_SLT);
    step(); chk("slt WB_R", V_WBR);
    step(); chk("slt->IF", V_IF);

    // lw: 5 cycles
    instr(6'b100011, 6'b000000);
    step(); chk("lw ID", V_ID);
    step(); chk("lw MEM_ADDR", V_MADDR);
    step(); chk("lw MEM_RD", V_MRD);
    step(); chk("lw WB_LW", V_WBLW);
    step(); chk("lw->IF", V_IF);

    // sw: 4 cycles
    instr(6'b101011, 6'b000000);
    step(); chk("sw ID", V_ID);
    step(); chk("sw MEM_ADDR", V_MADDR);
    step(); chk("sw MEM_WR", V_MWR);
    step(); chk("sw->IF", V_IF);

    // beq taken and not taken: same control, 3 cycles
    instr(6'b000100, 6'b000000);
    Zero = 1'b1;
    step(); chk("beq1 ID", V_ID);
    step(); chk("beq1 BEQ", V_BEQ);
    step(); chk("beq1->IF", V_IF);
    Zero = 1'b0;
    step(); chk("beq0 ID", V_ID);
    step(); chk("beq0 BEQ", V_BEQ);
    step(); chk("beq0->IF", V_IF);

    // j, jal, jr: 3 cycles each
    instr(6'b000010, 6'b000000);
    step(); chk("j ID", V_ID);
    step(); chk("j J", V_J);
    step(); chk("j->IF", V_IF);
    instr(6'b000011, 6'b000000);
    step(); chk("jal ID", V_ID);
    step(); chk("jal JAL", V_JAL);
    step(); chk("jal->IF", V_IF);
    instr(6'b000000, 6'b001000);
    step(); chk("jr ID", V_ID);
    step(); chk("jr JR", V_JR);
    step(); chk("jr->IF", V_IF);

    // addi: 4 cycles
    instr(6'b001000, 6'b000000);
    step(); chk("addi ID", V_ID);
    step(); chk("addi EX_I", V_EXI_ADD);
    step(); chk("addi WB_I", V_WBI);
    step(); chk("addi->IF", V_IF);

    // illegal opcode and illegal R funct: 2 cycles, single-cycle pulse
    instr(6'b111111, 6'b000000);
    step(); chk("badop ID", V_ID_ILL);
    step(); chk("badop->IF", V_IF);
    instr(6'b000000, 6'b000000);
    step(); chk("badfn ID", V_ID_ILL);
    step(); chk("badfn->IF", V_IF);

    // slti interrupted by reset during EX_I
    instr(6'b001010, 6'b000000);
    step(); chk("slti ID", V_ID);
    step(); chk("slti EX_I", V_EXI_SLT);
    rst = 1'b1;
    #1;
    chk("rst in EX_I", V_ZERO);
    step(); chk("rst held", V_ZERO);
    rst = 1'b0;
    #1;
    chk("rst->IF", V_IF);
    step(); chk("slti again ID", V_ID);
    step(); chk("slti again EX_I", V_EXI_SLT);
    step(); chk("slti WB_I", V_WBI);
    step(); chk("slti->IF", V_IF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mc_mips_controller.md
# mc_mips_controller

Multi-cycle MIPS main control unit: a Moore state machine that sequences each instruction through fetch, decode, execute, memory and write-back cycles. It drives every datapath write enable and every mux select (IorD, RegDst, MemtoReg, ALUSrcA, ALUSrcB, PCSrc) consumed by the 2/3/4-input datapath muxes, plus the ALU operation code. Sits beside the datapath in the top-level core and consumes only the IR opcode/funct fields and the ALU Zero flag.

## Interface
- No parameters.
- clk  in  1  core clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- Opcode  in  6  IR[31:26].
- Funct  in  6  IR[5:0].
- Zero  in  1  ALU zero flag (combinational from datapath).
- PCWrite  out  1  unconditional PC load.
- PCWriteCond  out  1  PC load qualified by Zero (datapath ANDs with Zero).
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut.
- MemRead  out  1  memory read strobe.
- MemWrite  out  1  memory write strobe.
- IRWrite  out  1  instruction register load.
- RegWrite  out  1  register file write.
- RegDst  out  2  write-register select: 00 = rt, 01 = rd, 10 = 31.
- MemtoReg  out  2  write-data select: 00 = ALUOut, 01 = MDR, 10 = PC.
- ALUSrcA  out  1  0 = PC, 1 = A.
- ALUSrcB  out  2  00 = B, 01 = 4, 10 = SignExt, 11 = SignExt<<2.
- PCSrc  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target, 11 = A.
- ALUCtrl  out  3  000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT.
- Illegal  out  1  one-cycle pulse in ID on unsupported opcode/funct.

## Operation
- Supported: R-type (opcode 000000) add 100000, sub 100010, and 100100, or 100101, slt 101010, jr 001000; lw 100011; sw 101011; beq 000100; j 000010; jal 000011; addi 001000; slti 001010.
- Moore outputs decoded from state (plus registered Funct decode in EX_R). In every state, any output not listed is 0.
- IF: MemRead, IorD=0, IRWrite, ALUSrcA=0, ALUSrcB=01, ALUCtrl=ADD, PCSrc=00, PCWrite. Next: ID.
- ID: ALUSrcA=0, ALUSrcB=11, ALUCtrl=ADD (branch target into ALUOut). Next by opcode: R (funct ≠ jr) → EX_R; R with jr → JR; lw/sw → MEM_ADDR; beq → BEQ; j → J; jal → JAL; addi/slti → EX_I; anything else (including unknown R funct) → IF with Illegal=1.
- EX_R: ALUSrcA=1, ALUSrcB=00, ALUCtrl from Funct. Next WB_R.
- WB_R: RegDst=01, MemtoReg=00, RegWrite. Next IF.
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ADD. Next MEM_RD (lw) or MEM_WR (sw).
- MEM_RD: MemRead, IorD=1. Next WB_LW.
- WB_LW: RegDst=00, MemtoReg=01, RegWrite. Next IF.
- MEM_WR: MemWrite, IorD=1. Next IF.
- BEQ: ALUSrcA=1, ALUSrcB=00, SUB, PCWriteCond, PCSrc=01. Next IF.
- J: PCWrite, PCSrc=10. Next IF.
- JAL: PCWrite, PCSrc=10, RegWrite, RegDst=10, MemtoReg=10 (PC already holds PC+4). Next IF.
- JR: PCWrite, PCSrc=11. Next IF.
- EX_I: ALUSrcA=1, ALUSrcB=10, ALUCtrl = ADD (addi) or SLT (slti). Next WB_I.
- WB_I: RegDst=00, MemtoReg=00, RegWrite. Next IF.
- Opcode is latched in the state register path only through the IR; controller itself holds no instruction copy beyond the state.

## Timing
- Reset: while rst=1, all enables (PCWrite, PCWriteCond, MemRead, MemWrite, IRWrite, RegWrite, Illegal) forced 0, all selects 00/0, ALUCtrl=000; state loads IF at the edge. First fetch occurs in the first cycle with rst=0.
- rst asserted mid-instruction: abandons instruction at the next edge; no partial write occurs in the reset cycle.
- Cycles per instruction (IF to next IF): R-type 4, addi/slti 4, lw 5, sw 4, beq 3, j/jal/jr 3, illegal 2.
- Illegal is asserted only in ID and only for one cycle; no datapath write in that instruction.
- Zero is not registered; branch decision uses Zero in the BEQ cycle.

## Test plan
- rst held 3 cycles then released → all enables 0 during reset; cycle after release MemRead=IRWrite=PCWrite=1, ALUSrcB=01.
- add (000000/100000) → IF, ID, EX_R (ALUCtrl=010, ALUSrcA=1), WB_R (RegWrite=1, RegDst=01); 4 cycles.
- lw then sw → lw: 5 cycles, MEM_RD has IorD=1 MemRead=1, WB_LW MemtoReg=01; sw: MEM_WR MemWrite=1, no RegWrite.
- beq with Zero=1 and Zero=0 → BEQ cycle PCWriteCond=1, PCSrc=01, ALUCtrl=110 both cases; 3 cycles.
- jal then jr → JAL: PCWrite=1, PCSrc=10, RegWrite=1, RegDst=10, MemtoReg=10; JR: PCSrc=11; 3 cycles each.
- opcode 111111, then R funct 000000, then rst asserted during EX_I of slti → Illegal pulses one cycle in ID, return to IF, no writes; reset returns to IF with no RegWrite.
